dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the address width of both requester ports and the memory port.
REQ-002 The block SHALL have parameter DATA_W, default 32, the data width of both requester ports and the memory port.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1 bit, SHALL be the only clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Ports p0_req/p1_req, input, 1 bit each, SHALL request one access from port 0 (CPU load/store) or port 1 (loader/debug).
REQ-007 Ports p0_we/p1_we, input, 1 bit each, SHALL select the access type: 1 = store, 0 = load.
REQ-008 Ports p0_addr/p1_addr, input, ADDR_W bits each, SHALL carry the byte address.
REQ-009 Ports p0_wdata/p1_wdata, input, DATA_W bits each, SHALL carry the store data.
REQ-010 Ports p0_funct3/p1_funct3, input, 3 bits each, SHALL carry the RISC-V load/store width code.
REQ-011 Ports p0_gnt/p1_gnt, output, 1 bit each, SHALL pulse for one cycle when a request is accepted.
REQ-012 Ports p0_done/p1_done, output, 1 bit each, SHALL pulse for one cycle when the transaction completes.
REQ-013 Ports p0_err/p1_err, output, 1 bit each, SHALL be valid with done and flag a rejected access.
REQ-014 Ports p0_rdata/p1_rdata, output, DATA_W bits each, SHALL carry the load result, valid with done.
REQ-015 Ports mem_MemRead/mem_MemWrite, output, 1 bit each, SHALL be the data-memory read and write strobes.
REQ-016 Ports mem_addr, mem_write_data and mem_funct3, outputs of ADDR_W, DATA_W and 3 bits, SHALL be the data-memory command fields.
REQ-017 Port mem_read_data, input, DATA_W bits, SHALL be the data memory's combinational, already-extended read result.

Function
REQ-018 The block SHALL implement a registered FSM with the states IDLE, ACCESS and RESP.
REQ-019 In IDLE with at least one req high, the block SHALL, at the next edge:
- pick one port;
- latch that port's we, addr, wdata and funct3;
- assert that port's gnt for the following cycle;
- go to ACCESS, or to RESP with err pending if the request is illegal.
REQ-020 Arbitration SHALL be round-robin: on simultaneous requests, the port not granted last SHALL win; a lone requester SHALL always win.
REQ-021 A request SHALL be illegal if any of the following holds:
- funct3 is 011, 110 or 111;
- funct3[1:0] = 01 (halfword) and addr[0] = 1;
- funct3[1:0] = 10 (word) and addr[1:0] != 0;
- we = 1 and funct3[2] = 1.
REQ-022 In ACCESS, the block SHALL drive mem_MemWrite = latched we and mem_MemRead = ~latched we for exactly one cycle.
REQ-023 In ACCESS, mem_addr, mem_write_data and mem_funct3 SHALL equal the latched values.
REQ-024 At the end of ACCESS, the block SHALL register mem_read_data for a load, or 0 for a store, and go to RESP.
REQ-025 In RESP, the block SHALL assert done of the granted port for one cycle, with rdata and err, then return to IDLE.
REQ-026 Latency SHALL be as follows:
- legal request: gnt 1 cycle after req is sampled, done 3 cycles after;
- illegal request: done 2 cycles after, with no memory strobe.
REQ-027 Both memory strobes SHALL be 0 outside ACCESS; mem_addr/mem_write_data/mem_funct3 SHALL hold their last latched values.
REQ-028 A requester SHALL hold req and its fields stable until done.
REQ-029 A req still high in the IDLE cycle after done SHALL be treated as a new request.
REQ-030 The ungranted port's gnt, done and err SHALL stay 0, and its rdata SHALL hold its last value.
REQ-031 Sustained throughput SHALL be one transaction per 3 cycles.

Reset
REQ-032 When rst is sampled high, at that edge the block SHALL:
- set the state to IDLE;
- clear all gnt, done, err and both strobes to 0;
- clear all rdata, mem_addr, mem_write_data and mem_funct3 to 0;
- set the last-granted pointer to port 1, so port 0 wins the first tie.
REQ-033 A reset during ACCESS or RESP SHALL abort the transaction: no done SHALL follow, and no strobe SHALL be asserted in the cycle after the reset edge.

Verification
REQ-034 Store/load: p0 SW 0xDEADBEEF to addr 0 -> mem_MemWrite high for exactly 1 cycle, p0_done 3 cycles after req; p0 LW addr 0 -> p0_rdata = 0xDEADBEEF, p0_err = 0.
REQ-035 Round-robin: p0_req and p1_req held high from reset -> grants alternate p0, p1, p0 on consecutive transactions, each done 3 cycles after its IDLE.
REQ-036 Sign extension: p1 SH 0x0000ABCD to addr 4 -> p1 LH addr 4 returns 0xFFFFABCD; p1 LHU addr 4 returns 0x0000ABCD.
REQ-037 Illegal requests: p0 LW addr 2, or p0 funct3 = 011 -> p0_done and p0_err high 2 cycles after req; no strobe asserted.
REQ-038 Reset abort: rst pulsed high for one edge while the FSM is in ACCESS for p1 -> IDLE next cycle, no p1_done, strobes 0; a subsequent p0 request is served normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter.
// Round-robin grants one load/store at a time, rejects misaligned or
// undefined accesses without touching memory, and returns each result
// through a registered IDLE -> ACCESS -> RESP sequence.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic [2:0]        p0_funct3,
   output logic              p0_gnt,
   output logic              p0_done,
   output logic              p0_err,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   input  logic [2:0]        p1_funct3,
   output logic              p1_gnt,
   output logic              p1_done,
   output logic              p1_err,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              mem_MemRead,
   output logic              mem_MemWrite,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic [2:0]        mem_funct3,
   input  logic [DATA_W-1:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state;
   logic              last_gnt;   // 1 = port 1 was granted most recently
   logic              sel;        // port owning the current transaction
   logic              lat_we;
   logic              err_pend;
   logic [DATA_W-1:0] rsp_data;

   logic              pick;
   logic              pick_we;
   logic [ADDR_W-1:0] pick_addr;
   logic [DATA_W-1:0] pick_wdata;
   logic [2:0]        pick_f3;
   logic              pick_bad;

   // Round-robin choice between the requesters and legality of the winner
   always_comb begin
      pick       = p1_req & (~p0_req | ~last_gnt);
      pick_we    = pick ? p1_we     : p0_we;
      pick_addr  = pick ? p1_addr   : p0_addr;
      pick_wdata = pick ? p1_wdata  : p0_wdata;
      pick_f3    = pick ? p1_funct3 : p0_funct3;
      pick_bad   = (pick_f3 == 3'b011) || (pick_f3 == 3'b110) || (pick_f3 == 3'b111)
                || ((pick_f3[1:0] == 2'b01) && pick_addr[0])
                || ((pick_f3[1:0] == 2'b10) && (pick_addr[1:0] != 2'b00))
                || (pick_we && pick_f3[2]);
   end

   // Transaction sequencer with registered grant, strobe and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         last_gnt       <= 1'b1;
         sel            <= 1'b0;
         lat_we         <= 1'b0;
         err_pend       <= 1'b0;
         rsp_data       <= '0;
         p0_gnt         <= 1'b0;
         p1_gnt         <= 1'b0;
         p0_done        <= 1'b0;
         p1_done        <= 1'b0;
         p0_err         <= 1'b0;
         p1_err         <= 1'b0;
         p0_rdata       <= '0;
         p1_rdata       <= '0;
         mem_MemRead    <= 1'b0;
         mem_MemWrite   <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         mem_funct3     <= '0;
      end else begin
         p0_gnt       <= 1'b0;
         p1_gnt       <= 1'b0;
         p0_done      <= 1'b0;
         p1_done      <= 1'b0;
         p0_err       <= 1'b0;
         p1_err       <= 1'b0;
         mem_MemRead  <= 1'b0;
         mem_MemWrite <= 1'b0;
         case (state)
            IDLE: begin
               if (p0_req || p1_req) begin
                  sel            <= pick;
                  last_gnt       <= pick;
                  lat_we         <= pick_we;
                  mem_addr       <= pick_addr;
                  mem_write_data <= pick_wdata;
                  mem_funct3     <= pick_f3;
                  if (pick) p1_gnt <= 1'b1;
                  else      p0_gnt <= 1'b1;
                  if (pick_bad) begin
                     err_pend <= 1'b1;
                     rsp_data <= '0;
                     state    <= RESP;
                  end else begin
                     err_pend     <= 1'b0;
                     mem_MemWrite <= pick_we;
                     mem_MemRead  <= ~pick_we;
                     state        <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               rsp_data <= lat_we ? '0 : mem_read_data;
               state    <= RESP;
            end
            RESP: begin
               if (sel) begin
                  p1_done  <= 1'b1;
                  p1_err   <= err_pend;
                  p1_rdata <= rsp_data;
               end else begin
                  p0_done  <= 1'b1;
                  p0_err   <= err_pend;
                  p0_rdata <= rsp_data;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-addressed memory behind the
// memory port, transaction-level reference memory for expected results.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p0_req = 1'b0, p0_we = 1'b0;
   logic [31:0] p0_addr = '0, p0_wdata = '0;
   logic [2:0]  p0_funct3 = '0;
   logic        p0_gnt, p0_done, p0_err;
   logic [31:0] p0_rdata;
   logic        p1_req = 1'b0, p1_we = 1'b0;
   logic [31:0] p1_addr = '0, p1_wdata = '0;
   logic [2:0]  p1_funct3 = '0;
   logic        p1_gnt, p1_done, p1_err;
   logic [31:0] p1_rdata;
   logic        mem_MemRead, mem_MemWrite;
   logic [31:0] mem_addr, mem_write_data, mem_read_data;
   logic [2:0]  mem_funct3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_funct3(p0_funct3), .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_err(p0_err),
      .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_funct3(p1_funct3), .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_err(p1_err),
      .p1_rdata(p1_rdata),
      .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_funct3(mem_funct3),
      .mem_read_data(mem_read_data)
   );

   // Environment memory: little-endian bytes, extended read data
   logic [7:0] env_mem [0:255];
   logic [7:0] e0, e1, e2, e3;
   assign e0 = env_mem[mem_addr[7:0]];
   assign e1 = env_mem[mem_addr[7:0] + 8'd1];
   assign e2 = env_mem[mem_addr[7:0] + 8'd2];
   assign e3 = env_mem[mem_addr[7:0] + 8'd3];

   always_comb begin
      mem_read_data = '0;
      case (mem_funct3)
         3'b000:  mem_read_data = {{24{e0[7]}}, e0};
         3'b001:  mem_read_data = {{16{e1[7]}}, e1, e0};
         3'b010:  mem_read_data = {e3, e2, e1, e0};
         3'b100:  mem_read_data = {24'd0, e0};
         3'b101:  mem_read_data = {16'd0, e1, e0};
         default: mem_read_data = '0;
      endcase
   end

   always @(posedge clk) begin
      if (mem_MemWrite) begin
         env_mem[mem_addr[7:0]] <= mem_write_data[7:0];
         if (mem_funct3[1:0] != 2'b00) env_mem[mem_addr[7:0] + 8'd1] <= mem_write_data[15:8];
         if (mem_funct3[1:0] == 2'b10) begin
            env_mem[mem_addr[7:0] + 8'd2] <= mem_write_data[23:16];
            env_mem[mem_addr[7:0] + 8'd3] <= mem_write_data[31:24];
         end
      end
   end

   // ---------------- reference model ----------------
   int unsigned ref_mem [0:255];

   function automatic bit legal(input logic we, input logic [31:0] addr, input logic [2:0] f3);
      if (f3 == 3 || f3 == 6 || f3 == 7) return 0;
      if (f3 % 4 == 1 && addr % 2 != 0) return 0;
      if (f3 % 4 == 2 && addr % 4 != 0) return 0;
      if (we && f3 >= 4) return 0;
      return 1;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
      int unsigned b0, b1, w;
      b0 = ref_mem[addr % 256];
      b1 = ref_mem[(addr + 1) % 256];
      w  = b0 + 256 * b1 + 65536 * ref_mem[(addr + 2) % 256] + 16777216 * ref_mem[(addr + 3) % 256];
      case (f3)
         3'd0: return (b0 >= 128) ? 32'(b0) + 32'hFFFFFF00 : 32'(b0);
         3'd1: return (b1 >= 128) ? 32'(b0 + 256 * b1) + 32'hFFFF0000 : 32'(b0 + 256 * b1);
         3'd2: return 32'(w);
         3'd4: return 32'(b0);
         default: return 32'(b0 + 256 * b1);
      endcase
   endfunction

   task automatic ref_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
      int unsigned n;
      n = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
      for (int unsigned i = 0; i < n; i++)
         ref_mem[(addr + i) % 256] = (data >> (8 * i)) % 256;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      p0_req = 1'b0;
      p1_req = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Issues one request on one port and observes until its done (bounded).
   task automatic run_txn(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          output int gnt_at, output int ngnt, output int done_at,
                          output logic [31:0] rdata, output logic err,
                          output int nwr, output int nrd, output int bus_bad, output int xtalk);
      logic [31:0] other_rd;
      gnt_at = -1; ngnt = 0; done_at = -1; rdata = '0; err = 1'b0;
      nwr = 0; nrd = 0; bus_bad = 0; xtalk = 0;
      if (port == 0) begin
         p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_funct3 = f3; p0_req = 1'b1;
         other_rd = p1_rdata;
      end else begin
         p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_funct3 = f3; p1_req = 1'b1;
         other_rd = p0_rdata;
      end
      for (int cyc = 1; cyc <= 8 && done_at < 0; cyc++) begin
         @(posedge clk); #1;
         if (port == 0 ? p0_gnt : p1_gnt) begin
            ngnt++;
            if (gnt_at < 0) gnt_at = cyc;
         end
         if (mem_MemWrite) nwr++;
         if (mem_MemRead) nrd++;
         if ((mem_MemWrite || mem_MemRead) &&
             (mem_addr !== addr || mem_funct3 !== f3 || (mem_MemWrite && mem_write_data !== wdata)))
            bus_bad++;
         if (port == 0) begin
            if (p1_gnt || p1_done || p1_err || p1_rdata !== other_rd) xtalk++;
         end else begin
            if (p0_gnt || p0_done || p0_err || p0_rdata !== other_rd) xtalk++;
         end
         if (port == 0 ? p0_done : p1_done) begin
            done_at = cyc;
            rdata   = (port == 0) ? p0_rdata : p1_rdata;
            err     = (port == 0) ? p0_err : p1_err;
         end
      end
      p0_req = 1'b0;
      p1_req = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err, mem_MemRead, mem_MemWrite} !== 8'd0) begin
         bad++;
         $display("FAIL reset_flags: got %b want 00000000",
                  {p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err, mem_MemRead, mem_MemWrite});
      end
      total++;
      if (p0_rdata !== 32'd0 || p1_rdata !== 32'd0) begin
         bad++;
         $display("FAIL reset_rdata: got %h/%h want 0/0", p0_rdata, p1_rdata);
      end
      total++;
      if (mem_addr !== 32'd0 || mem_write_data !== 32'd0 || mem_funct3 !== 3'd0) begin
         bad++;
         $display("FAIL reset_membus: got %h/%h/%0d want 0/0/0", mem_addr, mem_write_data, mem_funct3);
      end
      rst = 1'b0;
   endtask

   task automatic test_store_load();
      int g, ng, d, nw, nr, bb, xt;
      logic [31:0] rd;
      logic e;
      run_txn(0, 1'b1, 32'd0, 32'hDEADBEEF, 3'b010, g, ng, d, rd, e, nw, nr, bb, xt);
      ref_store(32'd0, 32'hDEADBEEF, 3'b010);
      total++;
      if (g !== 1 || ng !== 1) begin bad++; $display("FAIL sw_gnt: got at=%0d n=%0d want at=1 n=1", g, ng); end
      total++;
      if (d !== 3) begin bad++; $display("FAIL sw_done_at: got %0d want 3", d); end
      total++;
      if (nw !== 1 || nr !== 0) begin bad++; $display("FAIL sw_strobes: got wr=%0d rd=%0d want 1/0", nw, nr); end
      total++;
      if (bb !== 0 || xt !== 0 || e !== 1'b0 || rd !== 32'd0) begin
         bad++; $display("FAIL sw_resp: got bus=%0d xt=%0d err=%b rdata=%h want 0/0/0/0", bb, xt, e, rd);
      end
      run_txn(0, 1'b0, 32'd0, 32'd0, 3'b010, g, ng, d, rd, e, nw, nr, bb, xt);
      total++;
      if (rd !== ref_load(32'd0, 3'b010) || e !== 1'b0) begin
         bad++; $display("FAIL lw_rdata: got %h err=%b want %h err=0", rd, e, ref_load(32'd0, 3'b010));
      end
      total++;
      if (d !== 3 || nr !== 1 || nw !== 0) begin
         bad++; $display("FAIL lw_timing: got done=%0d rd=%0d wr=%0d want 3/1/0", d, nr, nw);
      end
   endtask

   task automatic test_sign_ext();
      int g, ng, d, nw, nr, bb, xt;
      logic [31:0] rd;
      logic e;
      run_txn(1, 1'b1, 32'd4, 32'h0000ABCD, 3'b001, g, ng, d, rd, e, nw, nr, bb, xt);
      ref_store(32'd4, 32'h0000ABCD, 3'b001);
      total++;
      if (d !== 3 || e !== 1'b0 || nw !== 1) begin
         bad++; $display("FAIL sh_resp: got done=%0d err=%b wr=%0d want 3/0/1", d, e, nw);
      end
      run_txn(1, 1'b0, 32'd4, 32'd0, 3'b001, g, ng, d, rd, e, nw, nr, bb, xt);
      total++;
      if (rd !== 32'hFFFFABCD || rd !== ref_load(32'd4, 3'b001)) begin
         bad++; $display("FAIL lh_sext: got %h want ffffabcd", rd);
      end
      run_txn(1, 1'b0, 32'd4, 32'd0, 3'b101, g, ng, d, rd, e, nw, nr, bb, xt);
      total++;
      if (rd !== 32'h0000ABCD || rd !== ref_load(32'd4, 3'b101)) begin
         bad++; $display("FAIL lhu_zext: got %h want 0000abcd", rd);
      end
   endtask

   task automatic test_illegal();
      int g, ng, d, nw, nr, bb, xt;
      logic [31:0] rd;
      logic e;
      run_txn(0, 1'b0, 32'd2, 32'd0, 3'b010, g, ng, d, rd, e, nw, nr, bb, xt);
      total++;
      if (d !== 2 || e !== 1'b1 || g !== 1) begin
         bad++; $display("FAIL lw_misaligned: got done=%0d err=%b gnt=%0d want 2/1/1", d, e, g);
      end
      total++;
      if (nw !== 0 || nr !== 0) begin bad++; $display("FAIL lw_misaligned_strobe: got wr=%0d rd=%0d want 0/0", nw, nr); end
      run_txn(0, 1'b0, 32'd0, 32'd0, 3'b011, g, ng, d, rd, e, nw, nr, bb, xt);
      total++;
      if (d !== 2 || e !== 1'b1 || nw !== 0 || nr !== 0) begin
         bad++; $display("FAIL f3_011: got done=%0d err=%b wr=%0d rd=%0d want 2/1/0/0", d, e, nw, nr);
      end
   endtask

   task automatic test_round_robin();
      int gp[$], gc[$], dp[$], dc[$];
      int exp_p[3] = '{0, 1, 0};
      int exp_g[3] = '{1, 4, 7};
      int exp_d[3] = '{3, 6, 9};
      do_reset();
      p0_we = 1'b0; p0_addr = 32'd0; p0_funct3 = 3'b010;
      p1_we = 1'b0; p1_addr = 32'd4; p1_funct3 = 3'b010;
      p0_req = 1'b1; p1_req = 1'b1;
      for (int cyc = 1; cyc <= 9; cyc++) begin
         @(posedge clk); #1;
         if (p0_gnt) begin gp.push_back(0); gc.push_back(cyc); end
         if (p1_gnt) begin gp.push_back(1); gc.push_back(cyc); end
         if (p0_done) begin dp.push_back(0); dc.push_back(cyc); end
         if (p1_done) begin dp.push_back(1); dc.push_back(cyc); end
      end
      p0_req = 1'b0; p1_req = 1'b0;
      total++;
      if (gp.size() != 3 || dp.size() != 3) begin
         bad++; $display("FAIL rr_counts: got gnts=%0d dones=%0d want 3/3", gp.size(), dp.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (gp[i] !== exp_p[i] || gc[i] !== exp_g[i] || dp[i] !== exp_p[i] || dc[i] !== exp_d[i]) begin
               bad++;
               $display("FAIL rr_txn%0d: got gnt p%0d@%0d done p%0d@%0d want gnt p%0d@%0d done p%0d@%0d",
                        i, gp[i], gc[i], dp[i], dc[i], exp_p[i], exp_g[i], exp_p[i], exp_d[i]);
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int g, ng, d, nw, nr, bb, xt;
      logic [31:0] rd, a, wd;
      logic e, we;
      logic [2:0] f3;
      int port;
      bit ok;
      int errs;
      errs = 0;
      for (int i = 0; i < 16; i++) begin
         wd = $urandom;
         run_txn(i % 2, 1'b1, 32'(4 * i), wd, 3'b010, g, ng, d, rd, e, nw, nr, bb, xt);
         ref_store(32'(4 * i), wd, 3'b010);
         if (d !== 3 || e !== 1'b0) errs++;
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL rand_prefill: got %0d bad stores want 0", errs); end
      for (int i = 0; i < 80; i++) begin
         port = int'($urandom_range(0, 1));
         we   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         a    = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) a = a & ~32'd3;
         wd   = $urandom;
         ok   = legal(we, a, f3);
         run_txn(port, we, a, wd, f3, g, ng, d, rd, e, nw, nr, bb, xt);
         total++;
         if (g !== 1 || ng !== 1 || d !== (ok ? 3 : 2) || e !== !ok) begin
            bad++;
            $display("FAIL rand_ctl%0d: p%0d we=%b f3=%0d a=%0d got gnt@%0d n=%0d done@%0d err=%b want gnt@1 n=1 done@%0d err=%b",
                     i, port, we, f3, a, g, ng, d, e, ok ? 3 : 2, !ok);
         end
         total++;
         if (nw !== int'(ok && we) || nr !== int'(ok && !we) || bb !== 0 || xt !== 0) begin
            bad++;
            $display("FAIL rand_bus%0d: got wr=%0d rd=%0d busbad=%0d xtalk=%0d want %0d/%0d/0/0",
                     i, nw, nr, bb, xt, int'(ok && we), int'(ok && !we));
         end
         if (ok) begin
            if (we) ref_store(a, wd, f3);
            total++;
            if (rd !== (we ? 32'd0 : ref_load(a, f3))) begin
               bad++;
               $display("FAIL rand_rdata%0d: f3=%0d a=%0d got %h want %h", i, f3, a, rd, we ? 32'd0 : ref_load(a, f3));
            end
         end
      end
   endtask

   task automatic test_reset_abort();
      int g, ng, d, nw, nr, bb, xt, late;
      logic [31:0] rd;
      logic e;
      p1_we = 1'b0; p1_addr = 32'd4; p1_funct3 = 3'b010; p1_req = 1'b1;
      @(posedge clk); #1;
      total++;
      if (p1_gnt !== 1'b1 || mem_MemRead !== 1'b1) begin
         bad++; $display("FAIL abort_in_access: got gnt=%b rd=%b want 1/1", p1_gnt, mem_MemRead);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      p1_req = 1'b0;
      total++;
      if (mem_MemRead !== 1'b0 || mem_MemWrite !== 1'b0 || p1_gnt !== 1'b0 || p1_done !== 1'b0 || mem_addr !== 32'd0) begin
         bad++;
         $display("FAIL abort_after_rst: got rd=%b wr=%b gnt=%b done=%b addr=%h want 0/0/0/0/0",
                  mem_MemRead, mem_MemWrite, p1_gnt, p1_done, mem_addr);
      end
      late = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (p1_done || mem_MemRead || mem_MemWrite) late++;
      end
      total++;
      if (late != 0) begin bad++; $display("FAIL abort_no_done: got %0d active cycles want 0", late); end
      run_txn(0, 1'b0, 32'd0, 32'd0, 3'b010, g, ng, d, rd, e, nw, nr, bb, xt);
      total++;
      if (d !== 3 || e !== 1'b0 || rd !== ref_load(32'd0, 3'b010)) begin
         bad++; $display("FAIL abort_recover: got done=%0d err=%b rdata=%h want 3/0/%h", d, e, rd, ref_load(32'd0, 3'b010));
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 0;
      test_reset();
      @(posedge clk); #1;
      test_store_load();
      test_sign_ext();
      test_illegal();
      test_round_robin();
      test_random();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
